// File: rtl/vdp_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vdp_pkg : shared constants and types for the VDP CPU-side port
// Revision: 1.0
// ---------------------------------------------------------------------------
package vdp_pkg;

  localparam logic [7:0] PORT_DATA = 8'hBE;
  localparam logic [7:0] PORT_CTRL = 8'hBF;

  localparam int ST_F_BIT  = 7;
  localparam int ST_5S_BIT = 6;
  localparam int ST_C_BIT  = 5;

  localparam logic [1:0] CTRL_OP_READ  = 2'b00;
  localparam logic [1:0] CTRL_OP_WRITE = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_REQ  = 2'd1,
    ST_RD_WAIT = 2'd2
  } fsm_state_t;

  function automatic logic is_reg_write(input logic [7:0] ctrl_byte);
    return ctrl_byte[7];
  endfunction

endpackage
`default_nettype wire

// File: rtl/vdp_status_reg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vdp_status_reg : F / 5S / C flags and fifth-sprite index, set wins over clear
// Revision: 1.0
// ---------------------------------------------------------------------------
module vdp_status_reg
  import vdp_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       vblank_set,
  input  logic       coll_set,
  input  logic       fifth_set,
  input  logic [4:0] fifth_num,
  input  logic       clear,
  output logic [7:0] status_q,
  output logic       flag_f
);

  logic       f_flag;
  logic       s5_flag;
  logic       c_flag;
  logic [4:0] fifth_idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      f_flag    <= 1'b0;
      s5_flag   <= 1'b0;
      c_flag    <= 1'b0;
      fifth_idx <= 5'd0;
    end else begin
      if (vblank_set)  f_flag <= 1'b1;
      else if (clear)  f_flag <= 1'b0;

      if (coll_set)    c_flag <= 1'b1;
      else if (clear)  c_flag <= 1'b0;

      // Only the first fifth-sprite event of a frame is kept.
      if (fifth_set && (!s5_flag || clear)) begin
        s5_flag   <= 1'b1;
        fifth_idx <= fifth_num;
      end else if (clear) begin
        s5_flag <= 1'b0;
      end
    end
  end

  always_comb begin
    status_q            = 8'h00;
    status_q[ST_F_BIT]  = f_flag;
    status_q[ST_5S_BIT] = s5_flag;
    status_q[ST_C_BIT]  = c_flag;
    status_q[4:0]       = s5_flag ? fifth_idx : 5'h1F;
  end

  assign flag_f = f_flag;

endmodule
`default_nettype wire

// File: rtl/vdp_cpu_port.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vdp_cpu_port : VDP CPU front end - control latch, VRAM address/prefetch, R0-R7, status
// Revision: 1.0
// ---------------------------------------------------------------------------
module vdp_cpu_port
  import vdp_pkg::*;
#(
  parameter int RD_LATENCY = 2,
  parameter int ADDR_W     = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_data,
  input  logic              wr_ctrl,
  input  logic              rd_data,
  input  logic              rd_ctrl,
  input  logic [7:0]        cpu_din,
  output logic [7:0]        data_q,
  output logic [7:0]        status_q,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [7:0]        vram_wdata,
  output logic              vram_wr,
  output logic              vram_rd,
  input  logic [7:0]        vram_q,
  input  logic              vblank_set,
  input  logic              coll_set,
  input  logic              fifth_set,
  input  logic [4:0]        fifth_num,
  output logic [63:0]       regs,
  output logic              int_n,
  output logic              busy,
  output logic              overrun
);

  localparam int CNT_W = 2;

  fsm_state_t         state;
  logic [CNT_W-1:0]   wait_cnt;
  logic               latch;
  logic [7:0]         tmp;
  logic [ADDR_W-1:0]  addr;
  logic [7:0][7:0]    reg_file;
  logic               pend_valid;
  logic [7:0]         pend_data;
  logic               restart;
  logic               skip_inc;
  logic               flag_f;

  logic ctrl_second, addr_load, read_setup, reg_write, trig, idle;
  logic issue_pend, direct_wr, to_slot, wr_issue, start_rd, capture;

  always_comb begin
    ctrl_second = wr_ctrl && latch;
    addr_load   = ctrl_second && !is_reg_write(cpu_din);
    read_setup  = addr_load && (cpu_din[7:6] == CTRL_OP_READ);
    reg_write   = ctrl_second && is_reg_write(cpu_din);
    trig        = rd_data || read_setup;
    idle        = (state == ST_IDLE);
    issue_pend  = idle && pend_valid;
    direct_wr   = wr_data && idle && !pend_valid;
    to_slot     = wr_data && !direct_wr;
    wr_issue    = issue_pend || direct_wr;
    // A VRAM write in flight takes the port first; the read is deferred.
    start_rd    = idle && !wr_issue && (trig || restart);
    capture     = (state == ST_RD_WAIT) && (wait_cnt == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      wait_cnt   <= '0;
      latch      <= 1'b0;
      tmp        <= 8'h00;
      addr       <= '0;
      reg_file   <= '0;
      pend_valid <= 1'b0;
      pend_data  <= 8'h00;
      restart    <= 1'b0;
      skip_inc   <= 1'b0;
      overrun    <= 1'b0;
      data_q     <= 8'h00;
      vram_wdata <= 8'h00;
      vram_wr    <= 1'b0;
      vram_rd    <= 1'b0;
    end else begin
      if (wr_data || rd_data || rd_ctrl) latch <= 1'b0;
      else if (wr_ctrl)                  latch <= !latch;
      if (wr_ctrl && !latch) tmp <= cpu_din;

      if (reg_write) reg_file[cpu_din[2:0]] <= tmp;

      // The counter advances after the cycle that used it, so vram_addr
      // always shows the address of the access currently on the port.
      if (addr_load)
        addr <= ADDR_W'({cpu_din[5:0], tmp});
      else if (vram_wr || (capture && !skip_inc))
        addr <= addr + 1'b1;

      if (start_rd)              skip_inc <= 1'b0;
      else if (addr_load && !idle) skip_inc <= 1'b1;

      if (start_rd)  restart <= 1'b0;
      else if (trig) restart <= 1'b1;

      if (to_slot) begin
        pend_valid <= 1'b1;
        pend_data  <= cpu_din;
        if (pend_valid && !issue_pend) overrun <= 1'b1;
      end else if (issue_pend) begin
        pend_valid <= 1'b0;
      end

      vram_wr <= wr_issue;
      if (wr_issue) begin
        vram_wdata <= issue_pend ? pend_data : cpu_din;
        data_q     <= issue_pend ? pend_data : cpu_din;
      end

      vram_rd <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_rd) begin
            state   <= ST_RD_REQ;
            vram_rd <= 1'b1;
          end
        end
        ST_RD_REQ: begin
          state    <= ST_RD_WAIT;
          wait_cnt <= CNT_W'(RD_LATENCY - 1);
        end
        ST_RD_WAIT: begin
          if (wait_cnt == '0) begin
            data_q <= vram_q;
            state  <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  vdp_status_reg u_status (
    .clk        (clk),
    .reset      (reset),
    .vblank_set (vblank_set),
    .coll_set   (coll_set),
    .fifth_set  (fifth_set),
    .fifth_num  (fifth_num),
    .clear      (rd_ctrl),
    .status_q   (status_q),
    .flag_f     (flag_f)
  );

  assign vram_addr = addr;
  assign regs      = reg_file;
  assign busy      = (state != ST_IDLE);
  assign int_n     = ~(flag_f & reg_file[1][5]);

endmodule
`default_nettype wire

// File: tb/tb_vdp_cpu_port.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_vdp_cpu_port : directed self-checking bench for vdp_cpu_port
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_vdp_cpu_port;

  localparam int L = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_data, wr_ctrl, rd_data, rd_ctrl;
  logic [7:0]  cpu_din;
  logic [7:0]  data_q, status_q, vram_wdata, vram_q;
  logic [13:0] vram_addr;
  logic        vram_wr, vram_rd;
  logic        vblank_set, coll_set, fifth_set;
  logic [4:0]  fifth_num;
  logic [63:0] regs;
  logic        int_n, busy, overrun;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vdp_cpu_port #(.RD_LATENCY(L), .ADDR_W(14)) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_data    (wr_data),
    .wr_ctrl    (wr_ctrl),
    .rd_data    (rd_data),
    .rd_ctrl    (rd_ctrl),
    .cpu_din    (cpu_din),
    .data_q     (data_q),
    .status_q   (status_q),
    .vram_addr  (vram_addr),
    .vram_wdata (vram_wdata),
    .vram_wr    (vram_wr),
    .vram_rd    (vram_rd),
    .vram_q     (vram_q),
    .vblank_set (vblank_set),
    .coll_set   (coll_set),
    .fifth_set  (fifth_set),
    .fifth_num  (fifth_num),
    .regs       (regs),
    .int_n      (int_n),
    .busy       (busy),
    .overrun    (overrun)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Each pulse task starts and ends on a falling edge.
  task automatic ctrl_wr(input logic [7:0] b);
    cpu_din = b; wr_ctrl = 1'b1;
    @(negedge clk);
    wr_ctrl = 1'b0;
  endtask

  task automatic data_wr(input logic [7:0] b);
    cpu_din = b; wr_data = 1'b1;
    @(negedge clk);
    wr_data = 1'b0;
  endtask

  task automatic status_rd();
    rd_ctrl = 1'b1;
    @(negedge clk);
    rd_ctrl = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; wr_data = 0; wr_ctrl = 0; rd_data = 0; rd_ctrl = 0;
    cpu_din = 8'h00; vram_q = 8'h5C; vblank_set = 0; coll_set = 0;
    fifth_set = 0; fifth_num = 5'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    check_eq("rst_regs",    regs, 64'h0);
    check_eq("rst_addr",    vram_addr, 14'h0000);
    check_eq("rst_data_q",  data_q, 8'h00);
    check_eq("rst_status",  status_q, 8'h1F);
    check_eq("rst_int_n",   int_n, 1'b1);
    check_eq("rst_strobes", {vram_wr, vram_rd, busy, overrun}, 4'b0000);

    // Write setup to 0x0734, then a data write.
    ctrl_wr(8'h34);
    ctrl_wr(8'h47);
    check_eq("wsetup_addr", vram_addr, 14'h0734);
    check_eq("wsetup_no_rd", {vram_rd, busy}, 2'b00);
    data_wr(8'hAA);
    check_eq("wr_strobe", {vram_wr, vram_addr, vram_wdata}, {1'b1, 14'h0734, 8'hAA});
    check_eq("wr_data_q", data_q, 8'hAA);
    @(negedge clk);
    check_eq("wr_addr_inc", {vram_wr, vram_addr}, {1'b0, 14'h0735});

    // Read setup at 0x1200 with prefetch.
    ctrl_wr(8'h00);
    ctrl_wr(8'h12);
    check_eq("rd_req", {vram_rd, vram_addr, busy}, {1'b1, 14'h1200, 1'b1});
    repeat (L) @(negedge clk);
    check_eq("rd_not_yet", data_q, 8'hAA);
    @(negedge clk);
    check_eq("rd_capture", data_q, 8'h5C);
    check_eq("rd_addr_inc", {vram_addr, busy}, {14'h1201, 1'b0});

    // Register write R1 = 0xE2 (IE set) and vblank interrupt.
    ctrl_wr(8'hE2);
    ctrl_wr(8'h81);
    check_eq("reg_r1", regs[15:8], 8'hE2);
    check_eq("int_idle", int_n, 1'b1);
    vblank_set = 1'b1; @(negedge clk); vblank_set = 1'b0;
    check_eq("vblank_f", status_q[7], 1'b1);
    check_eq("int_asserted", int_n, 1'b0);
    status_rd();
    check_eq("f_cleared", {status_q[7], int_n}, 2'b01);

    // Collision flag: set wins over a coincident status read.
    coll_set = 1'b1; @(negedge clk); coll_set = 1'b0;
    check_eq("coll_set", status_q[5], 1'b1);
    coll_set = 1'b1; rd_ctrl = 1'b1; @(negedge clk); coll_set = 1'b0; rd_ctrl = 1'b0;
    check_eq("coll_wins", status_q[5], 1'b1);
    status_rd();
    check_eq("coll_cleared", status_q[5], 1'b0);

    // First fifth-sprite event is kept.
    fifth_num = 5'd3; fifth_set = 1'b1; @(negedge clk); fifth_set = 1'b0;
    check_eq("fifth_first", status_q[6:0], {1'b1, 1'b0, 5'd3});
    fifth_num = 5'd9; fifth_set = 1'b1; @(negedge clk); fifth_set = 1'b0;
    check_eq("fifth_kept", status_q[4:0], 5'd3);
    status_rd();
    check_eq("status_clr", status_q, 8'h1F);

    // Address wrap from 0x3FFF.
    ctrl_wr(8'hFF);
    ctrl_wr(8'h7F);
    data_wr(8'h55);
    check_eq("wrap_wr", {vram_wr, vram_addr, vram_wdata}, {1'b1, 14'h3FFF, 8'h55});
    @(negedge clk);
    check_eq("wrap_addr", vram_addr, 14'h0000);

    // Status read clears the half-written control latch.
    ctrl_wr(8'h00);
    status_rd();
    ctrl_wr(8'h11);
    ctrl_wr(8'h43);
    check_eq("latch_clr_addr", vram_addr, 14'h0311);
    check_eq("latch_clr_busy", busy, 1'b0);

    // Two data writes while a prefetch is in progress.
    ctrl_wr(8'h00);
    ctrl_wr(8'h20);
    data_wr(8'h11);
    data_wr(8'h22);
    check_eq("overrun", overrun, 1'b1);
    begin
      int n = 0;
      while (!vram_wr && n < 10) begin
        @(negedge clk);
        n++;
      end
    end
    check_eq("pend_wr_seen", vram_wr, 1'b1);
    check_eq("pend_wr", {vram_addr, vram_wdata, data_q}, {14'h2001, 8'h22, 8'h22});

    // Reset while waiting for read data.
    ctrl_wr(8'h00);
    ctrl_wr(8'h05);
    @(negedge clk);
    check_eq("in_rd_wait", busy, 1'b1);
    reset = 1'b1; @(negedge clk); reset = 1'b0;
    check_eq("mid_rst", {busy, data_q, vram_addr, overrun}, {1'b0, 8'h00, 14'h0000, 1'b0});
    repeat (L + 1) @(negedge clk);
    check_eq("no_capture", {data_q, vram_rd, vram_wr}, {8'h00, 1'b0, 1'b0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
